// File: rtl/replay_sample_sequencer.sv
// rtl/replay_sample_sequencer.sv - replays timestamped poke records into a DUT on their target cycle
module replay_sample_sequencer #(
    parameter int DATA_W = 64,
    parameter int CYC_W  = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rec_valid,
    output logic              rec_ready,
    input  logic [CYC_W-1:0]  rec_cycle,
    input  logic [DATA_W-1:0] rec_data,
    input  logic              rec_last,
    output logic [DATA_W-1:0] poke_data,
    output logic              poke_valid,
    output logic [CYC_W-1:0]  cycles,
    output logic              exit,
    output logic              err_late
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [CYC_W-1:0]  mem_cycle [DEPTH];
    logic [DATA_W-1:0] mem_data  [DEPTH];
    logic              mem_last  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic              full;
    logic              empty;
    logic              push;
    logic              do_pop;
    logic              do_late;
    logic [CYC_W-1:0]  head_cycle;
    logic [DATA_W-1:0] head_data;
    logic              head_last;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Ready depends only on registered state; reset forces it low immediately.
    assign rec_ready = !reset && (state == RUN) && !full;
    assign push      = rec_valid && rec_ready;

    assign head_cycle = mem_cycle[rd_ptr];
    assign head_data  = mem_data[rd_ptr];
    assign head_last  = mem_last[rd_ptr];

    always_comb begin
        state_next = state;
        do_pop     = 1'b0;
        do_late    = 1'b0;
        case (state)
            RUN: begin
                if (!empty) begin
                    if (head_cycle == cycles) begin
                        do_pop = 1'b1;
                        if (head_last) begin
                            state_next = DONE;
                        end
                    end else if (head_cycle < cycles) begin
                        do_late    = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Payload storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_cycle[wr_ptr] <= rec_cycle;
            mem_data[wr_ptr]  <= rec_data;
            mem_last[wr_ptr]  <= rec_last;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycles     <= '0;
            poke_data  <= '0;
            poke_valid <= 1'b0;
            exit       <= 1'b0;
            err_late   <= 1'b0;
        end else begin
            if (state == RUN) begin
                cycles <= cycles + 1'b1;
            end
            poke_valid <= do_pop;
            if (do_pop) begin
                poke_data <= head_data;
            end
            if (do_late) begin
                err_late <= 1'b1;
            end
            if ((do_pop && head_last) || do_late) begin
                exit <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_replay_sample_sequencer.sv
// tb/tb_replay_sample_sequencer.sv - scoreboard bench for replay_sample_sequencer
module tb_replay_sample_sequencer;

    logic        clock;
    logic        reset;
    logic        rec_valid;
    logic        rec_ready;
    logic [63:0] rec_cycle;
    logic [63:0] rec_data;
    logic        rec_last;
    logic [63:0] poke_data;
    logic        poke_valid;
    logic [63:0] cycles;
    logic        exit;
    logic        err_late;

    replay_sample_sequencer #(
        .DATA_W(64),
        .CYC_W (64),
        .DEPTH (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_cycle (rec_cycle),
        .rec_data  (rec_data),
        .rec_last  (rec_last),
        .poke_data (poke_data),
        .poke_valid(poke_valid),
        .cycles    (cycles),
        .exit      (exit),
        .err_late  (err_late)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Expected output event: a poke pulse or the late flag, seen when the bench's edge count equals obs.
    typedef struct {
        bit          late;
        longint      obs;
        logic [63:0] data;
        bit          ex;
    } exp_t;

    exp_t   exp_q[$];
    longint last_pop;
    bit     model_done;
    longint tb_edges;

    always @(posedge clock or posedge reset) begin
        if (reset) tb_edges <= 0;
        else       tb_edges <= tb_edges + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        last_pop   = -1;
        model_done = 1'b0;
    endtask

    // A record is considered once it is both accepted and all earlier records have popped.
    task automatic model_accept(input longint acc, input longint ts, input logic [63:0] d, input bit l);
        longint es;
        exp_t   e;
        if (model_done) return;
        es = (acc + 1 > last_pop + 1) ? acc + 1 : last_pop + 1;
        if (ts >= es) begin
            e.late = 1'b0; e.obs = ts + 1; e.data = d; e.ex = l;
            exp_q.push_back(e);
            last_pop = ts;
            if (l) model_done = 1'b1;
        end else begin
            e.late = 1'b1; e.obs = es + 1; e.data = '0; e.ex = 1'b1;
            exp_q.push_back(e);
            model_done = 1'b1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit   prev_late;
        bit   late_rise;
        prev_late = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_late = 1'b0;
            end else begin
                late_rise = err_late && !prev_late;
                if (poke_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_poke", poke_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind_poke", 64'(e.late), 64'(0));
                        check("poke_time", tb_edges, e.obs);
                        check("poke_cycles", cycles, e.obs);
                        check("poke_data", poke_data, e.data);
                        check("poke_exit", exit, e.ex);
                    end
                end else if (late_rise) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_late", late_rise, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind_late", 64'(e.late), 64'(1));
                        check("late_time", tb_edges, e.obs);
                        check("late_cycles", cycles, e.obs);
                        check("late_exit", exit, 1'b1);
                    end
                end else if (exp_q.size() > 0 && tb_edges >= exp_q[0].obs) begin
                    e = exp_q.pop_front();
                    check("event_seen", poke_valid | late_rise, 1'b1);
                end
                prev_late = err_late;
            end
        end
    end

    task automatic push(input longint ts, input logic [63:0] d, input bit l, output longint acc);
        rec_cycle = 64'(ts);
        rec_data  = d;
        rec_last  = l;
        rec_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 300; k++) begin
            if (rec_ready) begin
                acc = tb_edges;
                model_accept(acc, ts, d, l);
                @(posedge clock);
                @(negedge clock);
                rec_valid = 1'b0;
                return;
            end
            @(negedge clock);
        end
        rec_valid = 1'b0;
        tests++;
        fails++;
        $display("FAIL push_timeout record_cycle=%0d never accepted", ts);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        model_flush();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("release_rec_ready", rec_ready, 1'b1);
        check("release_cycles", cycles, 64'd0);
    endtask

    task automatic wait_until(input longint n);
        for (int k = 0; k < 500 && tb_edges < n; k++) @(negedge clock);
    endtask

    longint acc;
    longint ts;
    int     n;

    initial begin : stimulus
        reset     = 1'b1;
        rec_valid = 1'b0;
        rec_cycle = '0;
        rec_data  = '0;
        rec_last  = 1'b0;
        model_flush();
        #1;
        check("reset_poke_valid", poke_valid, 1'b0);
        check("reset_poke_data", poke_data, 64'd0);
        check("reset_cycles", cycles, 64'd0);
        check("reset_exit", exit, 1'b0);
        check("reset_err_late", err_late, 1'b0);
        check("reset_rec_ready", rec_ready, 1'b0);

        do_reset();
        push(3, 64'hA5, 1'b0, acc);
        push(5, 64'h5A, 1'b1, acc);
        wait_until(15);
        check("basic_freeze_cycles", cycles, 64'd6);
        check("basic_exit", exit, 1'b1);
        check("basic_drained", exp_q.size(), 0);

        do_reset();
        for (int i = 0; i < 4; i++) push(40 + i, 64'(i + 1), 1'b0, acc);
        check("full_rec_ready", rec_ready, 1'b0);
        push(44, 64'h44, 1'b1, acc);
        check("fifth_accept_cycle", acc, 41);
        wait_until(50);
        check("full_drained", exp_q.size(), 0);

        do_reset();
        wait_until(10);
        push(2, 64'hBAD, 1'b0, acc);
        wait_until(16);
        check("late_err_late", err_late, 1'b1);
        check("late_exit", exit, 1'b1);
        check("late_rec_ready", rec_ready, 1'b0);
        check("late_drained", exp_q.size(), 0);

        do_reset();
        push(4, 64'h11, 1'b0, acc);
        push(4, 64'h22, 1'b0, acc);
        wait_until(12);
        check("dup_err_late", err_late, 1'b1);
        check("dup_drained", exp_q.size(), 0);

        do_reset();
        wait_until(20);
        push(25, 64'hC3, 1'b1, acc);
        wait_until(32);
        check("gap_cycles", cycles, 64'd26);
        check("gap_drained", exp_q.size(), 0);

        do_reset();
        push(3, 64'h77, 1'b0, acc);
        push(15, 64'h1, 1'b0, acc);
        push(16, 64'h2, 1'b0, acc);
        push(17, 64'h3, 1'b1, acc);
        wait_until(6);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("async_poke_data", poke_data, 64'd0);
        check("async_poke_valid", poke_valid, 1'b0);
        check("async_cycles", cycles, 64'd0);
        check("async_exit", exit, 1'b0);
        check("async_err_late", err_late, 1'b0);
        check("async_rec_ready", rec_ready, 1'b0);
        model_flush();
        @(negedge clock);
        reset = 1'b0;
        wait_until(30);
        check("async_no_replay_exit", exit, 1'b0);

        for (int it = 0; it < 8; it++) begin
            do_reset();
            ts = longint'($urandom_range(2, 6));
            n  = int'($urandom_range(3, 10));
            for (int i = 0; i < n && !model_done; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clock);
                push(ts, {$urandom, $urandom}, (i == n - 1), acc);
                ts = ts + longint'($urandom_range(0, 5));
            end
            for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(negedge clock);
            check("random_drained", exp_q.size(), 0);
            check("random_exit", exit, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/replay_sample_sequencer.md
REPLAY_SAMPLE_SEQUENCER -- requirements
Module: replay_sample_sequencer

Interface
REQ-001 Parameter: DATA_W, default 64, width of one poke sample record payload.
REQ-002 Parameter: CYC_W, default 64, width of record timestamp and internal cycle counter.
REQ-003 Parameter: DEPTH, default 4, record FIFO entries (power of two, >=2).
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rec_valid  in  1  upstream record valid.
REQ-007 rec_ready  out  1  FIFO can accept a record this cycle.
REQ-008 rec_cycle  in  CYC_W  target cycle at which rec_data is applied.
REQ-009 rec_data  in  DATA_W  poke values to drive into the DUT.
REQ-010 rec_last  in  1  record is final of trace.
REQ-011 poke_data  out  DATA_W  registered value driven to DUT inputs.
REQ-012 poke_valid  out  1  one-cycle pulse: poke_data updated this cycle.
REQ-013 cycles  out  CYC_W  current replay cycle count.
REQ-014 exit  out  1  sticky: trace complete or aborted; testbench finishes on it.
REQ-015 err_late  out  1  sticky: a head record targeted an already-passed cycle.

Function
REQ-016 Record accepted when rec_valid && rec_ready at rising edge; rec_cycle/rec_data/rec_last stored together in FIFO.
REQ-017 rec_ready SHALL be !full, derived from registered occupancy only; no combinational path from rec_valid.
REQ-018 Push and pop in same cycle SHALL be allowed when FIFO non-empty; occupancy unchanged.
REQ-019 Push into empty FIFO SHALL NOT be visible at head until following cycle (no bypass).
REQ-020 FSM states: RUN, DONE; reset state RUN.
REQ-021 In RUN, cycles SHALL increment by 1 each clock, wrapping modulo 2^CYC_W; in DONE, cycles SHALL hold.
REQ-022 In RUN, if FIFO non-empty and head.cycle == cycles: pop head; next cycle poke_data = head.data, poke_valid = 1.
REQ-023 In RUN, if FIFO non-empty and head.cycle < cycles (unsigned): do not pop; next cycle err_late = 1, exit = 1, state DONE.
REQ-024 In RUN, if FIFO empty or head.cycle > cycles: no pop; next cycle poke_valid = 0, poke_data holds.
REQ-025 At most one record popped per cycle; duplicate timestamps SHALL apply on successive cycles, the second flagged late per REQ-023.
REQ-026 Popping a record with last = 1 SHALL move FSM to DONE; exit = 1 in the same cycle poke_valid = 1 for that record.
REQ-027 In DONE: rec_ready = 0, no pops, poke_valid = 0, poke_data holds, exit and err_late held until reset.
REQ-028 Record apply latency: poke_valid asserts exactly one clock after the cycle where cycles == head.cycle.

Reset
REQ-029 On reset assertion, all outputs SHALL take reset values immediately, without waiting for a clock edge.
REQ-030 Reset values: poke_data = 0, poke_valid = 0, cycles = 0, exit = 0, err_late = 0, rec_ready = 0 while reset asserted.
REQ-031 Reset SHALL empty the FIFO and force state RUN, discarding in-flight records, including mid-trace.
REQ-032 First increment of cycles SHALL occur on first rising edge after reset deasserts; rec_ready = 1 from deassertion.

Verification
REQ-033 Push {cycle=3,data=0xA5}, {cycle=5,data=0x5A,last} back-to-back after reset -> poke_valid pulses when cycles reads 4 (data 0xA5) and 6 (data 0x5A); exit = 1 with second pulse; cycles freezes at 6.
REQ-034 DEPTH=4, push 5 records with distant timestamps, upstream holding valid -> rec_ready low after 4 accepted; fifth accepted the cycle after the first pop.
REQ-035 Push {cycle=2} when cycles already 10 -> err_late = 1, exit = 1 next cycle, no poke_valid, record left unpopped.
REQ-036 Two records both cycle=4 -> first applied (poke_valid at cycles=5), second flagged late next cycle, exit = 1.
REQ-037 Assert reset asynchronously between clock edges with 3 records queued -> outputs zero immediately; after release no poke_valid until new records pushed.
REQ-038 Empty FIFO for 20 cycles, then push {cycle=25,last} -> poke_valid = 0 throughout gap; single pulse when cycles reads 26; exit = 1.
